// File: rtl/frame_irq_ctrl.sv
// -----------------------------------------------------------------------------
// frame_irq_ctrl
//
// Sequences the handoff of each captured OV7725 frame between the pixel
// capture path and the AXI host. A frame is armed on a vsync rising edge,
// pixels written into the frame FIFO are counted, and once a full CNN input
// frame is buffered the host is interrupted. The next capture stays blocked
// until the host has cleared the interrupt and popped every pixel (or the
// drain timeout expires).
//
// Parameters:
//   FRAME_PIX  pixels per frame (28x28 CNN input)
//   PIX_W      width of the pixel / read counters (must hold FRAME_PIX)
//   TMO_CYC    maximum clk cycles spent in DRAIN before giving up
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   i_enable     capture enable from config register (level)
//   i_vsync      OV7725 vsync, already synchronised to clk
//   i_pix_vld    one pixel written into the frame FIFO this cycle
//   i_fifo_rd    host popped one pixel from the frame FIFO this cycle
//   i_irq_clr    one-cycle pulse from the interrupt-clear register write
//   i_err_clr    one-cycle pulse, clears the sticky error flags
//   o_cap_en     gate for the capture path
//   o_interrupt  frame-ready interrupt, level
//   o_pix_cnt    pixels captured in the current frame
//   o_rd_cnt     pixels popped by the host in the current handoff
//   o_frame_cnt  completed handoffs, wraps 0xFFFF -> 0
//   o_err_short  sticky: vsync edge arrived before a full frame
//   o_err_over   sticky: pop seen with nothing left to pop
//   o_err_tmo    sticky: drain timeout expired
//   o_state      current state (IDLE=0 WAIT_VS=1 CAPTURE=2 IRQ=3 DRAIN=4)
// -----------------------------------------------------------------------------
module frame_irq_ctrl #(
   parameter int FRAME_PIX = 784,
   parameter int PIX_W     = 16,
   parameter int TMO_CYC   = 1048576
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic             i_vsync,
   input  logic             i_pix_vld,
   input  logic             i_fifo_rd,
   input  logic             i_irq_clr,
   input  logic             i_err_clr,
   output logic             o_cap_en,
   output logic             o_interrupt,
   output logic [PIX_W-1:0] o_pix_cnt,
   output logic [PIX_W-1:0] o_rd_cnt,
   output logic [15:0]      o_frame_cnt,
   output logic             o_err_short,
   output logic             o_err_over,
   output logic             o_err_tmo,
   output logic [2:0]       o_state
);

   localparam int TMO_W = $clog2(TMO_CYC + 1);

   localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(FRAME_PIX);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      CAPTURE = 3'd2,
      IRQ     = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   // Registered state and its next-state values
   state_t             state,      state_n;
   logic               vs_d;
   logic               cap_en,     cap_en_n;
   logic               interrupt,  interrupt_n;
   logic [PIX_W-1:0]   pix_cnt,    pix_cnt_n;
   logic [PIX_W-1:0]   rd_cnt,     rd_cnt_n;
   logic [15:0]        frame_cnt,  frame_cnt_n;
   logic [TMO_W-1:0]   tmo_cnt,    tmo_cnt_n;
   logic               err_short,  err_short_n;
   logic               err_over,   err_over_n;
   logic               err_tmo,    err_tmo_n;

   // Error set events produced by the state logic
   logic               short_set;
   logic               tmo_set;

   // Read accounting shared by IRQ and DRAIN
   logic               vs_rise;
   logic               rd_ok;
   logic               rd_bad;
   logic [PIX_W-1:0]   rd_next;
   logic               rd_done;

   assign vs_rise = i_vsync & ~vs_d;

   // A pop is only counted while a handoff is open and pixels remain; any
   // other pop means the host read from a FIFO that holds nothing of ours.
   assign rd_ok   = i_fifo_rd & ((state == IRQ) || (state == DRAIN)) &
                    (rd_cnt != PIX_FULL);
   assign rd_bad  = i_fifo_rd & ~rd_ok;
   assign rd_next = rd_ok ? rd_cnt + 1'b1 : rd_cnt;
   // Includes a pop landing in the same cycle as the decision.
   assign rd_done = (rd_next == PIX_FULL);

   // ---------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      state_n     = state;
      cap_en_n    = cap_en;
      interrupt_n = interrupt;
      pix_cnt_n   = pix_cnt;
      rd_cnt_n    = rd_cnt;
      frame_cnt_n = frame_cnt;
      tmo_cnt_n   = tmo_cnt;
      short_set   = 1'b0;
      tmo_set     = 1'b0;

      unique case (state)
         IDLE: begin
            cap_en_n = 1'b0;
            if (i_enable) begin
               state_n = WAIT_VS;
            end
         end

         WAIT_VS: begin
            if (!i_enable) begin
               state_n = IDLE;
            end else if (vs_rise) begin
               state_n   = CAPTURE;
               pix_cnt_n = '0;
               cap_en_n  = 1'b1;
            end
         end

         CAPTURE: begin
            if (!i_enable) begin
               // Abandon the partial frame.
               state_n   = IDLE;
               cap_en_n  = 1'b0;
               pix_cnt_n = '0;
            end else if (i_pix_vld && (pix_cnt == PIX_LAST)) begin
               // The completing pixel wins over a coincident vsync edge.
               state_n     = IRQ;
               pix_cnt_n   = PIX_FULL;
               cap_en_n    = 1'b0;
               interrupt_n = 1'b1;
               rd_cnt_n    = '0;
            end else if (vs_rise) begin
               // Short frame: restart counting on the new frame.
               short_set = 1'b1;
               pix_cnt_n = '0;
            end else if (i_pix_vld && (pix_cnt != PIX_FULL)) begin
               pix_cnt_n = pix_cnt + 1'b1;
            end
         end

         IRQ: begin
            // The host may start popping before it clears the interrupt.
            rd_cnt_n = rd_next;
            if (i_irq_clr) begin
               interrupt_n = 1'b0;
               if (rd_done) begin
                  frame_cnt_n = frame_cnt + 16'd1;
                  state_n     = i_enable ? WAIT_VS : IDLE;
               end else begin
                  state_n   = DRAIN;
                  tmo_cnt_n = '0;
               end
            end
         end

         DRAIN: begin
            rd_cnt_n = rd_next;
            if (rd_done) begin
               frame_cnt_n = frame_cnt + 16'd1;
               state_n     = i_enable ? WAIT_VS : IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               // TMO_CYC cycles spent here: give up on this handoff.
               tmo_set = 1'b1;
               state_n = i_enable ? WAIT_VS : IDLE;
            end else begin
               tmo_cnt_n = tmo_cnt + 1'b1;
            end
         end

         default: begin
            state_n     = IDLE;
            cap_en_n    = 1'b0;
            interrupt_n = 1'b0;
         end
      endcase

      // Sticky flags: a set event in the same cycle as the clear wins.
      err_short_n = short_set | (err_short & ~i_err_clr);
      err_over_n  = rd_bad    | (err_over  & ~i_err_clr);
      err_tmo_n   = tmo_set   | (err_tmo   & ~i_err_clr);
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         // Starting high means a vsync already high at reset release is
         // never mistaken for a rising edge.
         vs_d      <= 1'b1;
         cap_en    <= 1'b0;
         interrupt <= 1'b0;
         pix_cnt   <= '0;
         rd_cnt    <= '0;
         frame_cnt <= '0;
         tmo_cnt   <= '0;
         err_short <= 1'b0;
         err_over  <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         state     <= state_n;
         vs_d      <= i_vsync;
         cap_en    <= cap_en_n;
         interrupt <= interrupt_n;
         pix_cnt   <= pix_cnt_n;
         rd_cnt    <= rd_cnt_n;
         frame_cnt <= frame_cnt_n;
         tmo_cnt   <= tmo_cnt_n;
         err_short <= err_short_n;
         err_over  <= err_over_n;
         err_tmo   <= err_tmo_n;
      end
   end

   // All outputs come straight from registers.
   assign o_cap_en    = cap_en;
   assign o_interrupt = interrupt;
   assign o_pix_cnt   = pix_cnt;
   assign o_rd_cnt    = rd_cnt;
   assign o_frame_cnt = frame_cnt;
   assign o_err_short = err_short;
   assign o_err_over  = err_over;
   assign o_err_tmo   = err_tmo;
   assign o_state     = state;

endmodule
